// File: rtl/dac_sched_pkg.sv
// Shared definitions for the DAC sample scheduler: register map, CTRL bits,
// channel state encoding and the saturating counter helper.
package dac_sched_pkg;

    localparam logic [2:0] ADR_CTRL   = 3'd0;
    localparam logic [2:0] ADR_DIV    = 3'd1;
    localparam logic [2:0] ADR_UNDER0 = 3'd2;
    localparam logic [2:0] ADR_UNDER1 = 3'd3;
    localparam logic [2:0] ADR_LATE0  = 3'd4;
    localparam logic [2:0] ADR_LATE1  = 3'd5;
    localparam logic [2:0] ADR_STATUS = 3'd6;

    localparam int CTRL_RUN = 0;
    localparam int CTRL_EN0 = 1;
    localparam int CTRL_EN1 = 2;
    localparam int CTRL_CLR = 3;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        LOADED = 2'd1,
        ISSUE  = 2'd2
    } chanState_t;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/dac_sched_chan.sv
// One scheduler channel: holding register, issue register and the
// EMPTY/LOADED/ISSUE state machine; state is exported for STATUS and debug.
module dac_sched_chan
    import dac_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tickEn,
    input  logic                  snkValid,
    input  logic [DATA_WIDTH-1:0] snkData,
    output logic                  snkRdy,
    output logic                  srcValid,
    output logic [DATA_WIDTH-1:0] srcData,
    input  logic                  srcRdy,
    output logic                  underEv,
    output logic                  lateEv,
    output chanState_t            chState
);

    // Handshakes: a transfer happens on an edge where valid and ready are both
    // high; ready/valid driven here depend only on registered state, and
    // srcValid is never dropped before srcRdy has been seen.
    chanState_t            state, nextState;
    logic [DATA_WIDTH-1:0] holdReg;
    logic [DATA_WIDTH-1:0] srcDataReg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= EMPTY;
            holdReg    <= '0;
            srcDataReg <= '0;
        end else begin
            state <= nextState;
            if (state == EMPTY && snkValid)
                holdReg <= snkData;
            if (state == LOADED && tickEn)
                srcDataReg <= holdReg;
        end
    end

    always_comb begin
        nextState = state;
        snkRdy    = 1'b0;
        srcValid  = 1'b0;
        underEv   = 1'b0;
        lateEv    = 1'b0;
        case (state)
            EMPTY: begin
                snkRdy  = 1'b1;
                underEv = tickEn;
                if (snkValid)
                    nextState = LOADED;
            end
            LOADED: begin
                if (tickEn)
                    nextState = ISSUE;
            end
            ISSUE: begin
                srcValid = 1'b1;
                lateEv   = tickEn;
                if (srcRdy)
                    nextState = EMPTY;
            end
            default: nextState = EMPTY;
        endcase
    end

    assign srcData = srcDataReg;
    assign chState = state;

endmodule

// File: rtl/dac_sample_sched.sv
// Sample-rate scheduler feeding both drvAd56x3 channels on a programmable tick.
// DAC_SCHED_UNDERRUN_CNT_EN adds the UNDER0/1 and LATE0/1 event counters.
module dac_sample_sched
    import dac_sched_pkg::*;
#(
    parameter int          DATA_WIDTH  = 14,
    parameter logic [15:0] DEFAULT_DIV = 16'd999
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            avsAdr,
    input  logic                  avsWr,
    input  logic [15:0]           avsWrData,
    input  logic                  avsRd,
    output logic [15:0]           avsRdData,
    input  logic                  snkValid0,
    input  logic [DATA_WIDTH-1:0] snkData0,
    output logic                  snkRdy0,
    input  logic                  snkValid1,
    input  logic [DATA_WIDTH-1:0] snkData1,
    output logic                  snkRdy1,
    output logic                  srcValid0,
    output logic [DATA_WIDTH-1:0] srcData0,
    input  logic                  srcRdy0,
    output logic                  srcValid1,
    output logic [DATA_WIDTH-1:0] srcData1,
    input  logic                  srcRdy1,
    output logic                  sampleTick
);

    logic        ctrlRun, ctrlEn0, ctrlEn1;
    logic [15:0] divReg, divCnt;
    logic        tickReg;
    logic        stickyUnder, stickyLate;
    logic        wrCtrl, wrDiv, clrCnt;
    logic [1:0]  tickEn, underEv, lateEv;
    chanState_t  chState0, chState1;
    logic [15:0] rdMux;

    assign wrCtrl = avsWr && (avsAdr == ADR_CTRL);
    assign wrDiv  = avsWr && (avsAdr == ADR_DIV);
    assign clrCnt = wrCtrl && avsWrData[CTRL_CLR];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrlRun <= 1'b0;
            ctrlEn0 <= 1'b0;
            ctrlEn1 <= 1'b0;
            divReg  <= DEFAULT_DIV;
        end else begin
            if (wrCtrl) begin
                ctrlRun <= avsWrData[CTRL_RUN];
                ctrlEn0 <= avsWrData[CTRL_EN0];
                ctrlEn1 <= avsWrData[CTRL_EN1];
            end
            if (wrDiv)
                divReg <= avsWrData;
        end
    end

    // A DIV write restarts the period so the new rate starts from a clean phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divCnt  <= '0;
            tickReg <= 1'b0;
        end else if (wrDiv || !ctrlRun) begin
            divCnt  <= '0;
            tickReg <= 1'b0;
        end else if (divCnt == divReg) begin
            divCnt  <= '0;
            tickReg <= 1'b1;
        end else begin
            divCnt  <= divCnt + 16'd1;
            tickReg <= 1'b0;
        end
    end

    assign sampleTick = tickReg;
    assign tickEn[0]  = tickReg && ctrlRun && ctrlEn0;
    assign tickEn[1]  = tickReg && ctrlRun && ctrlEn1;

    dac_sched_chan #(.DATA_WIDTH(DATA_WIDTH)) uChan0 (
        .clk      (clk),
        .reset    (reset),
        .tickEn   (tickEn[0]),
        .snkValid (snkValid0),
        .snkData  (snkData0),
        .snkRdy   (snkRdy0),
        .srcValid (srcValid0),
        .srcData  (srcData0),
        .srcRdy   (srcRdy0),
        .underEv  (underEv[0]),
        .lateEv   (lateEv[0]),
        .chState  (chState0)
    );

    dac_sched_chan #(.DATA_WIDTH(DATA_WIDTH)) uChan1 (
        .clk      (clk),
        .reset    (reset),
        .tickEn   (tickEn[1]),
        .snkValid (snkValid1),
        .snkData  (snkData1),
        .snkRdy   (snkRdy1),
        .srcValid (srcValid1),
        .srcData  (srcData1),
        .srcRdy   (srcRdy1),
        .underEv  (underEv[1]),
        .lateEv   (lateEv[1]),
        .chState  (chState1)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stickyUnder <= 1'b0;
            stickyLate  <= 1'b0;
        end else if (clrCnt) begin
            stickyUnder <= 1'b0;
            stickyLate  <= 1'b0;
        end else begin
            stickyUnder <= stickyUnder | (|underEv);
            stickyLate  <= stickyLate | (|lateEv);
        end
    end

`ifdef DAC_SCHED_UNDERRUN_CNT_EN
    logic [1:0][CNT_W-1:0] underCnt, lateCnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underCnt <= '0;
            lateCnt  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (clrCnt)
                    underCnt[i] <= '0;
                else if (underEv[i])
                    underCnt[i] <= satInc(underCnt[i]);
                if (clrCnt)
                    lateCnt[i] <= '0;
                else if (lateEv[i])
                    lateCnt[i] <= satInc(lateCnt[i]);
            end
        end
    end
`endif

    always_comb begin
        rdMux = '0;
        case (avsAdr)
            ADR_CTRL:   rdMux = {13'd0, ctrlEn1, ctrlEn0, ctrlRun};
            ADR_DIV:    rdMux = divReg;
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
            ADR_UNDER0: rdMux = underCnt[0];
            ADR_UNDER1: rdMux = underCnt[1];
            ADR_LATE0:  rdMux = lateCnt[0];
            ADR_LATE1:  rdMux = lateCnt[1];
`endif
            ADR_STATUS: rdMux = {10'd0, stickyLate, stickyUnder, 2'(chState1), 2'(chState0)};
            default:    rdMux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            avsRdData <= '0;
        else if (avsRd)
            avsRdData <= rdMux;
    end

endmodule

// File: tb/tb_dac_sample_sched.sv
// Self-checking bench for dac_sample_sched: transaction-level model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_dac_sample_sched;

    localparam int DW = 14;
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk, reset;
    logic [2:0]    avsAdr;
    logic          avsWr, avsRd;
    logic [15:0]   avsWrData, avsRdData;
    logic          snkValid0, snkValid1, snkRdy0, snkRdy1;
    logic [DW-1:0] snkData0, snkData1, srcData0, srcData1;
    logic          srcValid0, srcValid1, srcRdy0, srcRdy1;
    logic          sampleTick;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    dac_sample_sched #(.DATA_WIDTH(DW), .DEFAULT_DIV(16'd999)) dut (
        .clk(clk), .reset(reset),
        .avsAdr(avsAdr), .avsWr(avsWr), .avsWrData(avsWrData),
        .avsRd(avsRd), .avsRdData(avsRdData),
        .snkValid0(snkValid0), .snkData0(snkData0), .snkRdy0(snkRdy0),
        .snkValid1(snkValid1), .snkData1(snkData1), .snkRdy1(snkRdy1),
        .srcValid0(srcValid0), .srcData0(srcData0), .srcRdy0(srcRdy0),
        .srcValid1(srcValid1), .srcData1(srcData1), .srcRdy1(srcRdy1),
        .sampleTick(sampleTick)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    bit          mRun, mEn[2];
    int          mDiv, mCnt;
    bit          mTick;
    bit          hasHold[2], outValid[2];
    logic [DW-1:0] holdVal[2], outVal[2];
    int          mUnder[2], mLate[2];
    bit          stickU, stickL;
    logic [15:0] mRd;

    function automatic logic [1:0] stateCode(input int i);
        return outValid[i] ? 2'd2 : (hasHold[i] ? 2'd1 : 2'd0);
    endfunction

    function automatic logic [15:0] readModel(input logic [2:0] a);
        case (a)
            3'd0: return {13'd0, mEn[1], mEn[0], mRun};
            3'd1: return 16'(mDiv);
            3'd2: return CNT_EN ? 16'(mUnder[0]) : 16'd0;
            3'd3: return CNT_EN ? 16'(mUnder[1]) : 16'd0;
            3'd4: return CNT_EN ? 16'(mLate[0]) : 16'd0;
            3'd5: return CNT_EN ? 16'(mLate[1]) : 16'd0;
            3'd6: return {10'd0, stickL, stickU, stateCode(1), stateCode(0)};
            default: return 16'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mRun = 0; mEn[0] = 0; mEn[1] = 0; mDiv = 999; mCnt = 0; mTick = 0;
            stickU = 0; stickL = 0; mRd = 16'd0;
            for (int i = 0; i < 2; i++) begin
                hasHold[i] = 0; outValid[i] = 0; holdVal[i] = '0; outVal[i] = '0;
                mUnder[i] = 0; mLate[i] = 0;
            end
        end else begin
            bit ue[2], le[2], te, sv, rdy, clr;
            logic [DW-1:0] sd;
            if (avsRd) mRd = readModel(avsAdr);
            for (int i = 0; i < 2; i++) begin
                ue[i] = 0; le[i] = 0;
                te  = mTick && mRun && mEn[i];
                sv  = (i == 0) ? snkValid0 : snkValid1;
                sd  = (i == 0) ? snkData0 : snkData1;
                rdy = (i == 0) ? srcRdy0 : srcRdy1;
                if (outValid[i]) begin
                    le[i] = te;
                    if (rdy) outValid[i] = 0;
                end else if (hasHold[i]) begin
                    if (te) begin outVal[i] = holdVal[i]; outValid[i] = 1; hasHold[i] = 0; end
                end else begin
                    ue[i] = te;
                    if (sv) begin holdVal[i] = sd; hasHold[i] = 1; end
                end
            end
            clr = avsWr && avsAdr == 3'd0 && avsWrData[3];
            for (int i = 0; i < 2; i++) begin
                if (clr) begin mUnder[i] = 0; mLate[i] = 0; end
                else begin
                    if (ue[i] && mUnder[i] < 65535) mUnder[i]++;
                    if (le[i] && mLate[i] < 65535) mLate[i]++;
                end
            end
            if (clr) begin stickU = 0; stickL = 0; end
            else begin
                stickU = stickU | ue[0] | ue[1];
                stickL = stickL | le[0] | le[1];
            end
            if ((avsWr && avsAdr == 3'd1) || !mRun) begin mCnt = 0; mTick = 0; end
            else if (mCnt == mDiv) begin mCnt = 0; mTick = 1; end
            else begin mCnt++; mTick = 0; end
            if (avsWr && avsAdr == 3'd0) begin
                mRun = avsWrData[0]; mEn[0] = avsWrData[1]; mEn[1] = avsWrData[2];
            end
            if (avsWr && avsAdr == 3'd1) mDiv = int'(avsWrData);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("sampleTick", 32'(sampleTick), 32'(mTick));
            check("srcValid0", 32'(srcValid0), 32'(outValid[0]));
            check("srcValid1", 32'(srcValid1), 32'(outValid[1]));
            check("srcData0", 32'(srcData0), 32'(outVal[0]));
            check("srcData1", 32'(srcData1), 32'(outVal[1]));
            check("snkRdy0", 32'(snkRdy0), 32'(!hasHold[0] && !outValid[0]));
            check("snkRdy1", 32'(snkRdy1), 32'(!hasHold[1] && !outValid[1]));
            check("avsRdData", 32'(avsRdData), 32'(mRd));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic doReset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic writeReg(input logic [2:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        avsAdr = a; avsWrData = d; avsWr = 1'b1;
        @(posedge clk); #1;
        avsWr = 1'b0;
    endtask

    task automatic readReg(input string name, input logic [2:0] a, input logic [15:0] exp);
        @(posedge clk); #1;
        avsAdr = a; avsRd = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        avsRd = 1'b0;
        check(name, 32'(avsRdData), 32'(exp_q.pop_front()));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc, n, ticks, lastRise;
        bit ok;
        logic [DW-1:0] held;
        reset = 1'b0; avsAdr = '0; avsWr = 0; avsRd = 0; avsWrData = '0;
        snkValid0 = 0; snkValid1 = 0; snkData0 = '0; snkData1 = '0;
        srcRdy0 = 0; srcRdy1 = 0;
        #1;
        check("rst_snkRdy0", 32'(snkRdy0), 1);
        check("rst_srcValid1", 32'(srcValid1), 0);
        check("rst_rdData", 32'(avsRdData), 0);
        doReset();

        // reset values and read-back
        readReg("rd_div_reset", 3'd1, 16'd999);
        readReg("rd_ctrl_reset", 3'd0, 16'd0);
        writeReg(3'd1, 16'd9);
        writeReg(3'd0, 16'd7);
        readReg("rd_div9", 3'd1, 16'd9);
        readReg("rd_ctrl7", 3'd0, 16'd7);
        readReg("rd_adr7", 3'd7, 16'd0);

        // rate: both channels continuously fed and drained
        doReset();
        snkValid0 = 1; snkValid1 = 1; srcRdy0 = 1; srcRdy1 = 1;
        writeReg(3'd1, 16'd9);
        writeReg(3'd0, 16'd7);
        n = 0; lastRise = -1; cyc = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            cyc++;
            check("rate_pair", 32'(srcValid0), 32'(srcValid1));
            if (srcValid0) begin
                if (lastRise >= 0) check("rate_period", 32'(cyc - lastRise), 10);
                lastRise = cyc; n++;
            end
            snkData0 = DW'($urandom); snkData1 = DW'($urandom);
        end
        check("rate_pulses", 32'(n >= 6), 1);
        readReg("rate_under0", 3'd2, 16'd0);
        readReg("rate_late1", 3'd5, 16'd0);

        // underrun: both sources idle for three ticks
        doReset();
        snkValid0 = 0; snkValid1 = 0; srcRdy0 = 1; srcRdy1 = 1;
        writeReg(3'd1, 16'd4);
        writeReg(3'd0, 16'd7);
        ticks = 0;
        for (int k = 0; k < 100 && ticks < 3; k++) begin
            @(negedge clk);
            if (sampleTick) ticks++;
        end
        check("under_ticks_seen", 32'(ticks), 3);
        avsAdr = 3'd0; avsWrData = 16'd0; avsWr = 1;
        @(posedge clk); #1 avsWr = 0;
        readReg("under0_cnt", 3'd2, CNT_EN ? 16'd3 : 16'd0);
        readReg("under1_cnt", 3'd3, CNT_EN ? 16'd3 : 16'd0);
        readReg("under_status", 3'd6, 16'h0010);
        writeReg(3'd0, 16'h000F);
        readReg("under0_clr", 3'd2, 16'd0);
        readReg("under_status_clr", 3'd6, 16'h0000);
        writeReg(3'd0, 16'd0);

        // late: ch1 issue held off by the driver, ticking every cycle
        doReset();
        snkValid1 = 1; snkData1 = DW'(14'h2A5); srcRdy1 = 0; srcRdy0 = 1;
        writeReg(3'd1, 16'd0);
        writeReg(3'd0, 16'd5);
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = srcValid1;
        end
        check("late_issue_seen", 32'(ok), 1);
        held = srcData1;
        check("late_data_lit", 32'(held), 32'(14'h2A5));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            snkData1 = DW'($urandom);
            check("late_valid_hold", 32'(srcValid1), 1);
            check("late_data_hold", 32'(srcData1), 32'(held));
        end
        avsAdr = 3'd0; avsWrData = 16'd0; avsWr = 1; srcRdy1 = 1;
        @(posedge clk); #1 avsWr = 0; srcRdy1 = 0;
        readReg("late1_cnt", 3'd5, CNT_EN ? 16'd6 : 16'd0);
        readReg("late_status", 3'd6, 16'h0024);

        // disable while ch0 is issuing
        doReset();
        snkValid0 = 1; snkValid1 = 0; srcRdy0 = 0; srcRdy1 = 1;
        writeReg(3'd1, 16'd4);
        writeReg(3'd0, 16'd3);
        ok = 0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            ok = srcValid0;
        end
        check("dis_issue_seen", 32'(ok), 1);
        snkValid0 = 0;
        writeReg(3'd0, 16'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("dis_valid_kept", 32'(srcValid0), 1);
        end
        srcRdy0 = 1;
        @(posedge clk); #1 srcRdy0 = 0;
        check("dis_done_valid", 32'(srcValid0), 0);
        check("dis_done_rdy", 32'(snkRdy0), 1);
        ticks = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (sampleTick || srcValid0) ticks++;
        end
        check("dis_no_ticks", 32'(ticks), 0);

        // async reset while both channels are issuing
        doReset();
        snkValid0 = 1; snkValid1 = 1; srcRdy0 = 0; srcRdy1 = 0;
        writeReg(3'd1, 16'd2);
        writeReg(3'd0, 16'd7);
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            ok = srcValid0 && srcValid1;
        end
        check("ar_issue_seen", 32'(ok), 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #3 reset = 1'b0;
        #1;
        check("ar_srcValid0", 32'(srcValid0), 0);
        check("ar_srcValid1", 32'(srcValid1), 0);
        check("ar_snkRdy0", 32'(snkRdy0), 1);
        check("ar_snkRdy1", 32'(snkRdy1), 1);
        check("ar_tick", 32'(sampleTick), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        snkValid0 = 0; snkValid1 = 0;
        readReg("ar_late0", 3'd4, 16'd0);
        readReg("ar_status", 3'd6, 16'd0);
        readReg("ar_div", 3'd1, 16'd999);

        // randomized traffic against the model
        doReset();
        writeReg(3'd1, 16'($urandom_range(0, 6)));
        writeReg(3'd0, 16'h0007);
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            snkValid0 = ($urandom_range(0, 3) != 0);
            snkValid1 = ($urandom_range(0, 2) == 0);
            snkData0  = DW'($urandom);
            snkData1  = DW'($urandom);
            srcRdy0   = ($urandom_range(0, 1) == 1);
            srcRdy1   = ($urandom_range(0, 4) != 0);
            avsRd     = ($urandom_range(0, 3) == 0);
            avsWr     = 0;
            avsAdr    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) begin
                avsWr = 1; avsAdr = 3'd0;
                avsWrData = {12'd0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                             1'($urandom_range(0, 5) != 0)};
            end else if ($urandom_range(0, 79) == 0) begin
                avsWr = 1; avsAdr = 3'd1; avsWrData = 16'($urandom_range(0, 6));
            end else if ($urandom_range(0, 59) == 0) begin
                avsWr = 1; avsAdr = 3'($urandom_range(2, 7)); avsWrData = 16'($urandom);
            end
        end
        @(posedge clk); #1;
        avsWr = 0; avsRd = 0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
